// File: rtl/vc_grant_arbiter_pkg.sv
// Shared constants for the VC grant arbiter and the request chain it consumes.
// Holds the FSM state encoding and the default VC count / index width.
package vc_grant_arbiter_pkg;

  localparam int DEF_NUM_VC = 8;
  localparam int DEF_IDX_W  = 3;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/vc_grant_arbiter_if.sv
// Request/grant bundle between the input VC buffers (master) and the arbiter (slave).
interface vc_grant_arbiter_if
  import vc_grant_arbiter_pkg::*;
#(
  parameter int NUM_VC = DEF_NUM_VC,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int CNT_W  = DEF_CNT_W
);

  logic [NUM_VC-1:0] vc_req;
  logic [NUM_VC-1:0] vc_tail;
  logic              out_ready;
  logic              grant_valid;
  logic [IDX_W-1:0]  grant_idx;
  logic [NUM_VC-1:0] vc_grant;
  logic [NUM_VC-1:0] vc_pop;
  logic [CNT_W-1:0]  flit_cnt;

  modport master (
    output vc_req, vc_tail, out_ready,
    input  grant_valid, grant_idx, vc_grant, vc_pop, flit_cnt
  );

  modport slave (
    input  vc_req, vc_tail, out_ready,
    output grant_valid, grant_idx, vc_grant, vc_pop, flit_cnt
  );

endinterface

// File: rtl/vc_rr_pick.sv
// Combinational winner selection over the VC request flags.
// VC_ARB_ROUND_ROBIN_EN: search upward from rrPtr with wrap; otherwise lowest index wins.
module vc_rr_pick #(
  parameter int NUM_VC = 8,
  parameter int IDX_W  = 3
) (
  input  logic [NUM_VC-1:0] vcReq,
`ifdef VC_ARB_ROUND_ROBIN_EN
  input  logic [IDX_W-1:0]  rrPtr,
`endif
  output logic              any,
  output logic [IDX_W-1:0]  idx
);

`ifdef VC_ARB_ROUND_ROBIN_EN
  int               cand;
  logic [IDX_W-1:0] candIdx;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    any     = |vcReq;
    idx     = '0;
    cand    = 0;
    candIdx = '0;
    for (int off = NUM_VC - 1; off >= 0; off--) begin
      cand = int'(rrPtr) + off;
      if (cand >= NUM_VC) cand = cand - NUM_VC;
      candIdx = IDX_W'(cand);
      if (vcReq[candIdx]) idx = candIdx;
    end
  end
`else
  always_comb begin
    any = |vcReq;
    idx = '0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      if (vcReq[i]) idx = IDX_W'(i);
    end
  end
`endif

endmodule

// File: rtl/vc_grant_arbiter.sv
// Per-port VC grant arbiter: picks a VC, holds it for a whole packet, pops one flit per transfer.
// VC_ARB_ROUND_ROBIN_EN selects rotating priority; undefined gives fixed lowest-index priority.
module vc_grant_arbiter
  import vc_grant_arbiter_pkg::*;
#(
  parameter int NUM_VC = DEF_NUM_VC,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic               clk,
  input logic               rst_n,
  vc_grant_arbiter_if.slave bus
);

  arb_state_e       stateQ, stateD;
  logic [IDX_W-1:0] grantIdxQ, grantIdxD;
  logic [CNT_W-1:0] flitCntQ, flitCntD;
  logic             pickAny;
  logic [IDX_W-1:0] pickIdx;
  logic             xfer;
  logic             isBusy;

`ifdef VC_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rrPtrQ, rrPtrD;
`endif

  vc_rr_pick #(
    .NUM_VC(NUM_VC),
    .IDX_W (IDX_W)
  ) u_pick (
    .vcReq(bus.vc_req),
`ifdef VC_ARB_ROUND_ROBIN_EN
    .rrPtr(rrPtrQ),
`endif
    .any  (pickAny),
    .idx  (pickIdx)
  );

  assign isBusy = (stateQ == ST_BUSY);
  // A flit moves only when the owner still has one and the link takes it.
  assign xfer   = isBusy && bus.out_ready && bus.vc_req[grantIdxQ];

  always_comb begin
    stateD    = stateQ;
    grantIdxD = grantIdxQ;
    flitCntD  = flitCntQ;
`ifdef VC_ARB_ROUND_ROBIN_EN
    rrPtrD    = rrPtrQ;
`endif
    unique case (stateQ)
      ST_IDLE: begin
        if (pickAny) begin
          stateD    = ST_BUSY;
          grantIdxD = pickIdx;
          flitCntD  = '0;
        end
      end
      ST_BUSY: begin
        if (xfer) begin
          if (flitCntQ != {CNT_W{1'b1}}) flitCntD = flitCntQ + 1'b1;
          if (bus.vc_tail[grantIdxQ]) begin
            stateD = ST_IDLE;
`ifdef VC_ARB_ROUND_ROBIN_EN
            rrPtrD = (grantIdxQ == IDX_W'(NUM_VC - 1)) ? '0 : grantIdxQ + 1'b1;
`endif
          end
        end
      end
      default: stateD = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= ST_IDLE;
      grantIdxQ <= '0;
      flitCntQ  <= '0;
`ifdef VC_ARB_ROUND_ROBIN_EN
      rrPtrQ    <= '0;
`endif
    end else begin
      stateQ    <= stateD;
      grantIdxQ <= grantIdxD;
      flitCntQ  <= flitCntD;
`ifdef VC_ARB_ROUND_ROBIN_EN
      rrPtrQ    <= rrPtrD;
`endif
    end
  end

  always_comb begin
    bus.vc_grant = '0;
    if (isBusy) bus.vc_grant[grantIdxQ] = 1'b1;
  end

  assign bus.vc_pop      = xfer ? bus.vc_grant : '0;
  assign bus.grant_valid = isBusy;
  assign bus.grant_idx   = grantIdxQ;
  assign bus.flit_cnt    = flitCntQ;

endmodule

// File: tb/tb_vc_grant_arbiter.sv
// Directed self-checking bench for vc_grant_arbiter (NUM_VC=8, CNT_W=4).
// Expected grant order follows VC_ARB_ROUND_ROBIN_EN when it is defined.
module tb_vc_grant_arbiter;

  localparam int NUM_VC = 8;
  localparam int IDX_W  = 3;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int nChecks = 0;
  int nFails  = 0;

  vc_grant_arbiter_if #(.NUM_VC(NUM_VC), .IDX_W(IDX_W), .CNT_W(CNT_W)) arbIf ();

  vc_grant_arbiter #(.NUM_VC(NUM_VC), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (arbIf.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic [7:0] tail;
    logic       rdy;
    logic       expValid;
    logic [2:0] expIdx;
    logic [7:0] expPop;
    logic [3:0] expCnt;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs mid-cycle, let combinational outputs settle, then sample.
  task automatic step(input logic [7:0] req, input logic [7:0] tail, input logic rdy);
    @(negedge clk);
    arbIf.vc_req    = req;
    arbIf.vc_tail   = tail;
    arbIf.out_ready = rdy;
    #1;
  endtask

  task automatic checkOut(input string tag, input logic expValid, input logic [2:0] expIdx,
                          input logic [7:0] expPop, input logic [3:0] expCnt);
    logic [7:0] expGrant;
    expGrant = expValid ? (8'h01 << expIdx) : 8'h00;
    check({tag, ".valid"}, 32'(arbIf.grant_valid), 32'(expValid));
    if (expValid) check({tag, ".idx"}, 32'(arbIf.grant_idx), 32'(expIdx));
    check({tag, ".grant"}, 32'(arbIf.vc_grant), 32'(expGrant));
    check({tag, ".pop"}, 32'(arbIf.vc_pop), 32'(expPop));
    check({tag, ".cnt"}, 32'(arbIf.flit_cnt), 32'(expCnt));
  endtask

  logic [2:0] rotExp[4];
  logic [7:0] tl;

  initial begin
    arbIf.vc_req    = '0;
    arbIf.vc_tail   = '0;
    arbIf.out_ready = 1'b0;

    // Single 3-flit packet on VC2, then stall/empty handling on VC5, then a 1-flit packet on VC0.
    vecs[0]  = '{8'h04, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0};
    vecs[1]  = '{8'h04, 8'h00, 1'b1, 1'b1, 3'd2, 8'h04, 4'd0};
    vecs[2]  = '{8'h04, 8'h00, 1'b1, 1'b1, 3'd2, 8'h04, 4'd1};
    vecs[3]  = '{8'h04, 8'h04, 1'b1, 1'b1, 3'd2, 8'h04, 4'd2};
    vecs[4]  = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 4'd3};
    vecs[5]  = '{8'h20, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 4'd3};
    vecs[6]  = '{8'h20, 8'h00, 1'b1, 1'b1, 3'd5, 8'h20, 4'd0};
    vecs[7]  = '{8'h20, 8'h00, 1'b0, 1'b1, 3'd5, 8'h00, 4'd1};
    vecs[8]  = '{8'h20, 8'h00, 1'b1, 1'b1, 3'd5, 8'h20, 4'd1};
    vecs[9]  = '{8'h01, 8'h00, 1'b1, 1'b1, 3'd5, 8'h00, 4'd2};
    vecs[10] = '{8'h01, 8'h00, 1'b1, 1'b1, 3'd5, 8'h00, 4'd2};
    vecs[11] = '{8'h21, 8'h20, 1'b1, 1'b1, 3'd5, 8'h20, 4'd2};
    vecs[12] = '{8'h01, 8'h01, 1'b1, 1'b0, 3'd0, 8'h00, 4'd3};
    vecs[13] = '{8'h01, 8'h01, 1'b1, 1'b1, 3'd0, 8'h01, 4'd0};
    vecs[14] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 4'd1};

`ifdef VC_ARB_ROUND_ROBIN_EN
    rotExp = '{3'd0, 3'd1, 3'd7, 3'd0};
`else
    rotExp = '{3'd0, 3'd0, 3'd0, 3'd0};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    checkOut("reset", 1'b0, 3'd0, 8'h00, 4'd0);
    check("reset.idx0", 32'(arbIf.grant_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].req, vecs[i].tail, vecs[i].rdy);
      checkOut($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expIdx, vecs[i].expPop,
               vecs[i].expCnt);
    end

    // Reset mid-packet: VC2 granted, two flits out, then asynchronous reset.
    step(8'h04, 8'h00, 1'b1);
    checkOut("mid.idle", 1'b0, 3'd0, 8'h00, 4'd1);
    step(8'h04, 8'h00, 1'b1);
    checkOut("mid.f0", 1'b1, 3'd2, 8'h04, 4'd0);
    step(8'h04, 8'h00, 1'b1);
    checkOut("mid.f1", 1'b1, 3'd2, 8'h04, 4'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOut("mid.rst", 1'b0, 3'd0, 8'h00, 4'd0);
    step(8'h04, 8'h00, 1'b1);
    checkOut("mid.rsthold", 1'b0, 3'd0, 8'h00, 4'd0);
    @(negedge clk);
    arbIf.vc_req = 8'h00;
    rst_n = 1'b1;

    // Rotation with 1-flit packets; first grant from a cleared pointer.
    for (int k = 0; k < 4; k++) begin
      step(8'h83, 8'h83, 1'b1);
      check($sformatf("rot%0d.bubble", k), 32'(arbIf.grant_valid), 32'd0);
      check($sformatf("rot%0d.bubblepop", k), 32'(arbIf.vc_pop), 32'd0);
      step(8'h83, 8'h83, 1'b1);
      checkOut($sformatf("rot%0d", k), 1'b1, rotExp[k], 8'h01 << rotExp[k], 4'd0);
    end

    // Wrap-around: VC7 released, pointer wraps, VC0 wins over VC7.
    step(8'h80, 8'h80, 1'b1);
    check("wrap.idle0", 32'(arbIf.grant_valid), 32'd0);
    step(8'h80, 8'h80, 1'b1);
    checkOut("wrap.vc7", 1'b1, 3'd7, 8'h80, 4'd0);
    step(8'h81, 8'h81, 1'b1);
    check("wrap.idle1", 32'(arbIf.grant_valid), 32'd0);
    step(8'h81, 8'h81, 1'b1);
    checkOut("wrap.vc0", 1'b1, 3'd0, 8'h01, 4'd0);

    // Saturation: 20-flit packet on VC3 with a 4-bit counter.
    step(8'h08, 8'h00, 1'b1);
    check("sat.idle", 32'(arbIf.grant_valid), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tl = (i == 19) ? 8'h08 : 8'h00;
      step(8'h08, tl, 1'b1);
      checkOut($sformatf("sat%0d", i), 1'b1, 3'd3, 8'h08, (i > 15) ? 4'd15 : 4'(i));
    end
    step(8'h00, 8'h00, 1'b1);
    checkOut("sat.release", 1'b0, 3'd0, 8'h00, 4'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
